// File: rtl/clk_time_reader_if.sv
// Read-port bundle between a host and clk_time_reader.
// rd_parity exists only when CLK_TIME_READER_PARITY_EN is defined.
interface clk_time_reader_if #(
    parameter int DATA_W = 8
);
    logic              rd_req;
    logic [1:0]        rd_addr;
    logic              rd_busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
`ifdef CLK_TIME_READER_PARITY_EN
    logic              rd_parity;
`endif

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_busy,
        input  rd_valid,
        input  rd_data
`ifdef CLK_TIME_READER_PARITY_EN
        ,
        input  rd_parity
`endif
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_busy,
        output rd_valid,
        output rd_data
`ifdef CLK_TIME_READER_PARITY_EN
        ,
        output rd_parity
`endif
    );
endinterface

// File: rtl/clk_time_reader.sv
// Addressed read port for the real-clock seconds/minutes counters, with a
// tear-free min:sec snapshot and optional BCD output. Optional: CLK_TIME_READER_PARITY_EN.
module clk_time_reader #(
    parameter int CONV_STEPS = 6,
    parameter int DATA_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         seconds_in,
    input  logic [5:0]         minutes_in,
    clk_time_reader_if.slave   bus
);
    localparam int CNT_W = $clog2(CONV_STEPS + 1);

    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

    state_t            state_q;
    logic [1:0]        addr_q;
    logic [5:0]        snap_sec_q;
    logic [5:0]        snap_min_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [5:0]        bin_q;
    logic [7:0]        bcd_q;
    logic              rd_busy_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [7:0]        bcd_adj;
    logic [7:0]        bcd_d;
    logic [5:0]        bin_d;
    logic [DATA_W-1:0] resp_d;

    // One double-dabble iteration: correct nibbles >= 5, then shift left.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
        bcd_d = {bcd_adj[6:0], bin_q[5]};
        bin_d = {bin_q[4:0], 1'b0};
    end

    always_comb begin
        resp_d = '0;
        if (addr_q[1]) resp_d = DATA_W'(bcd_q);
        else           resp_d = DATA_W'(addr_q[0] ? snap_min_q : snap_sec_q);
    end

`ifdef CLK_TIME_READER_PARITY_EN
    logic rd_parity_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            snap_sec_q <= '0;
            snap_min_q <= '0;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            rd_busy_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef CLK_TIME_READER_PARITY_EN
            rd_parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    rd_valid_q <= 1'b0;
                    rd_busy_q  <= 1'b0;
                    if (bus.rd_req) begin
                        addr_q    <= bus.rd_addr;
                        rd_busy_q <= 1'b1;
                        // Seconds reads refresh both halves so a following
                        // minutes read matches the same instant.
                        if (!bus.rd_addr[0]) begin
                            snap_sec_q <= seconds_in;
                            snap_min_q <= minutes_in;
                        end
                        if (bus.rd_addr[1]) begin
                            state_q <= CONV;
                            bin_q   <= bus.rd_addr[0] ? snap_min_q : seconds_in;
                            bcd_q   <= '0;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                CONV: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    if (cnt_q == CNT_W'(CONV_STEPS - 1)) begin
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    // Busy stays up through the cycle that carries rd_valid.
                    state_q    <= IDLE;
                    rd_valid_q <= 1'b1;
                    rd_busy_q  <= 1'b1;
                    rd_data_q  <= resp_d;
`ifdef CLK_TIME_READER_PARITY_EN
                    rd_parity_q <= ^resp_d;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_busy  = rd_busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
`ifdef CLK_TIME_READER_PARITY_EN
    assign bus.rd_parity = rd_parity_q;
`endif
endmodule

// File: tb/tb_clk_time_reader.sv
// Scoreboard bench for clk_time_reader: stimulus queues expected responses,
// a negedge monitor pops and checks data and arrival cycle.
module tb_clk_time_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] seconds_in = '0;
    logic [5:0] minutes_in = '0;

    clk_time_reader_if #(.DATA_W(8)) bus ();

    clk_time_reader #(.CONV_STEPS(6), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .seconds_in (seconds_in),
        .minutes_in (minutes_in),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ncnt   = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (negedge %0d)", name, act, exp, ncnt);
        end
    endtask

    // Monitor: every rd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        ncnt = ncnt + 1;
        if (bus.rd_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: rd_valid high with data 0x%0h, none expected (negedge %0d)",
                         bus.rd_data, ncnt);
            end else begin
                e = q.pop_front();
                check("rd_data", int'(bus.rd_data), int'(e.data));
                check("valid_cycle", ncnt, e.due);
`ifdef CLK_TIME_READER_PARITY_EN
                check("rd_parity", int'(bus.rd_parity), int'(^e.data));
`endif
            end
        end
    end

    task automatic wait_idle(input string name, input int exp_busy);
        int n = 0;
        while (bus.rd_busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk); #1;
        end
        check(name, n, exp_busy);
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [5:0] sec, input logic [5:0] mn,
                           input logic [7:0] exp_data, input string name);
        int lat;
        lat = addr[1] ? 7 : 1;
        @(negedge clk); #1;
        seconds_in  = sec;
        minutes_in  = mn;
        bus.rd_addr = addr;
        bus.rd_req  = 1'b1;
        q.push_back('{exp_data, ncnt + 1 + lat});
        @(negedge clk); #1;
        bus.rd_req = 1'b0;
        wait_idle(name, addr[1] ? 8 : 2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy",  int'(bus.rd_busy),  0);
        check("reset_valid", int'(bus.rd_valid), 0);
        check("reset_data",  int'(bus.rd_data),  0);
        reset = 1'b0;

        do_read(2'b00, 6'd37, 6'd12, 8'h25, "busy_bin_37");
        do_read(2'b00, 6'd59, 6'd4,  8'h3B, "busy_bin_59");
        do_read(2'b01, 6'd0,  6'd5,  8'h04, "busy_min_snap");
        do_read(2'b10, 6'd47, 6'd59, 8'h47, "busy_bcd_47");
        do_read(2'b11, 6'd10, 6'd30, 8'h59, "busy_bcd_min59");
        do_read(2'b10, 6'd63, 6'd0,  8'h63, "busy_bcd_63");
        do_read(2'b01, 6'd20, 6'd20, 8'h00, "busy_min_zero");
        do_read(2'b00, 6'd63, 6'd1,  8'h3F, "busy_bin_63");
        do_read(2'b10, 6'd0,  6'd1,  8'h00, "busy_bcd_0");
        do_read(2'b10, 6'd9,  6'd1,  8'h09, "busy_bcd_9");
        do_read(2'b10, 6'd10, 6'd1,  8'h10, "busy_bcd_10");

        // Request pulsed mid-conversion must be dropped.
        @(negedge clk); #1;
        seconds_in = 6'd25; minutes_in = 6'd7;
        bus.rd_addr = 2'b10; bus.rd_req = 1'b1;
        q.push_back('{8'h25, ncnt + 8});
        @(negedge clk); #1;
        bus.rd_req = 1'b0;
        bus.rd_addr = 2'b00;
        seconds_in = 6'd50;
        @(negedge clk); #1;
        bus.rd_req = 1'b1;
        @(negedge clk); #1;
        bus.rd_req = 1'b0;
        wait_idle("busy_ignored", 6);
        do_read(2'b01, 6'd0, 6'd0, 8'h07, "busy_min_after_ignore");

        // Held request re-triggers on each return to IDLE.
        @(negedge clk); #1;
        seconds_in = 6'd5; minutes_in = 6'd6;
        bus.rd_addr = 2'b00; bus.rd_req = 1'b1;
        n0 = ncnt;
        q.push_back('{8'h05, n0 + 2});
        q.push_back('{8'h05, n0 + 4});
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        bus.rd_req = 1'b0;
        wait_idle("busy_retrigger", 2);

        // Reset on the third conversion cycle aborts without a response.
        @(negedge clk); #1;
        seconds_in = 6'd33; bus.rd_addr = 2'b10; bus.rd_req = 1'b1;
        @(negedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        check("abort_data",  int'(bus.rd_data),  0);
        check("abort_busy",  int'(bus.rd_busy),  0);
        check("abort_valid", int'(bus.rd_valid), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        do_read(2'b01, 6'd44, 6'd44, 8'h00, "busy_min_after_abort");

        repeat (10) @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
